// File: rtl/control_unit_if.sv
// Control strobe bundle between the hardwired sequencer and the datapath.
// master = sequencer (drives strobes), slave = datapath (drives IR/stop).
interface control_unit_if;
  localparam int unsigned IR_W  = 32;
  localparam int unsigned ALU_W = 5;

  logic [IR_W-1:0]  IR_Data;
  logic             stop;
  logic             run;
  logic             PC_enable;
  logic             PC_increment_enable;
  logic             IR_enable;
  logic             Y_enable;
  logic             Z_enable;
  logic             MAR_enable;
  logic             MDR_enable;
  logic             r_enable;
  logic             con_enable;
  logic             manual_R15_enable;
  logic             outport_enable;
  logic             read;
  logic             write;
  logic             Gra;
  logic             Grb;
  logic             BAout;
  logic             PC_select;
  logic             Z_LO_select;
  logic             MDR_select;
  logic             c_select;
  logic             r_select;
  logic             inport_select;
  logic [ALU_W-1:0] alu_instruction;

  modport master (
    input  IR_Data, stop,
    output run, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
           MAR_enable, MDR_enable, r_enable, con_enable, manual_R15_enable,
           outport_enable, read, write, Gra, Grb, BAout, PC_select, Z_LO_select,
           MDR_select, c_select, r_select, inport_select, alu_instruction
  );

  modport slave (
    output IR_Data, stop,
    input  run, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
           MAR_enable, MDR_enable, r_enable, con_enable, manual_R15_enable,
           outport_enable, read, write, Gra, Grb, BAout, PC_select, Z_LO_select,
           MDR_select, c_select, r_select, inport_select, alu_instruction
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, decode opcode in T3, per-instruction
// execute steps. Strobes decode from state (T3 also from the loaded opcode).
module control_unit (
  input  logic           clk,
  input  logic           reset_n,
  control_unit_if.master bus
);
  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;
  localparam logic [OP_W-1:0] ALU_ADD = 5'b00001;

  // Execute steps are split per instruction so later steps never re-read IR.
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4_LDI, S_T5_LDI,
    S_T4_LD, S_T5_LD, S_T6_LD, S_T7_LD,
    S_T4_ST, S_T5_ST, S_T6_ST, S_T7_ST,
    S_HALT
  } state_t;

  state_t          state, state_next;
  logic [OP_W-1:0] opcode;

  assign opcode = bus.IR_Data[31:27];

  // State register; async reset drops every strobe (incl. write) immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_next;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next              = state;
    bus.run                 = 1'b0;
    bus.PC_enable           = 1'b0;
    bus.PC_increment_enable = 1'b0;
    bus.IR_enable           = 1'b0;
    bus.Y_enable            = 1'b0;
    bus.Z_enable            = 1'b0;
    bus.MAR_enable          = 1'b0;
    bus.MDR_enable          = 1'b0;
    bus.r_enable            = 1'b0;
    bus.con_enable          = 1'b0;
    bus.manual_R15_enable   = 1'b0;
    bus.outport_enable      = 1'b0;
    bus.read                = 1'b0;
    bus.write               = 1'b0;
    bus.Gra                 = 1'b0;
    bus.Grb                 = 1'b0;
    bus.BAout               = 1'b0;
    bus.PC_select           = 1'b0;
    bus.Z_LO_select         = 1'b0;
    bus.MDR_select          = 1'b0;
    bus.c_select            = 1'b0;
    bus.r_select            = 1'b0;
    bus.inport_select       = 1'b0;
    bus.alu_instruction     = '0;

    unique case (state)
      S_RST:  state_next = S_T0;
      S_T0: begin
        bus.run = 1'b1; bus.PC_select = 1'b1; bus.MAR_enable = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        bus.run = 1'b1; bus.PC_increment_enable = 1'b1;
        bus.read = 1'b1; bus.MDR_enable = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        bus.run = 1'b1; bus.MDR_select = 1'b1; bus.IR_enable = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        bus.run = 1'b1;
        case (opcode)
          OP_LDI, OP_LD, OP_ST: begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1;
            state_next = (opcode == OP_LDI) ? S_T4_LDI :
                         (opcode == OP_LD)  ? S_T4_LD  : S_T4_ST;
          end
          OP_IN: begin
            bus.inport_select = 1'b1; bus.Gra = 1'b1; bus.r_enable = 1'b1;
            state_next = bus.stop ? S_HALT : S_T0;
          end
          OP_OUT: begin
            bus.Gra = 1'b1; bus.r_select = 1'b1; bus.outport_enable = 1'b1;
            state_next = bus.stop ? S_HALT : S_T0;
          end
          OP_HALT: state_next = S_HALT;
          default: state_next = bus.stop ? S_HALT : S_T0;
        endcase
      end
      S_T4_LDI, S_T4_LD, S_T4_ST: begin
        bus.run = 1'b1; bus.c_select = 1'b1;
        bus.alu_instruction = ALU_ADD; bus.Z_enable = 1'b1;
        state_next = (state == S_T4_LDI) ? S_T5_LDI :
                     (state == S_T4_LD)  ? S_T5_LD  : S_T5_ST;
      end
      S_T5_LDI: begin
        bus.run = 1'b1; bus.Z_LO_select = 1'b1; bus.Gra = 1'b1; bus.r_enable = 1'b1;
        state_next = bus.stop ? S_HALT : S_T0;
      end
      S_T5_LD, S_T5_ST: begin
        bus.run = 1'b1; bus.Z_LO_select = 1'b1; bus.MAR_enable = 1'b1;
        state_next = (state == S_T5_LD) ? S_T6_LD : S_T6_ST;
      end
      S_T6_LD: begin
        bus.run = 1'b1; bus.read = 1'b1; bus.MDR_enable = 1'b1;
        state_next = S_T7_LD;
      end
      S_T7_LD: begin
        bus.run = 1'b1; bus.MDR_select = 1'b1; bus.Gra = 1'b1; bus.r_enable = 1'b1;
        state_next = bus.stop ? S_HALT : S_T0;
      end
      S_T6_ST: begin
        bus.run = 1'b1; bus.Gra = 1'b1; bus.r_select = 1'b1; bus.MDR_enable = 1'b1;
        state_next = S_T7_ST;
      end
      S_T7_ST: begin
        bus.run = 1'b1; bus.write = 1'b1;
        state_next = bus.stop ? S_HALT : S_T0;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: compares every control step against a
// per-instruction strobe table, using directed and random instruction streams.
module tb_control_unit;
  typedef struct packed {
    logic       run;
    logic       PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic       MAR_enable, MDR_enable, r_enable, con_enable, manual_R15_enable;
    logic       outport_enable, read, write, Gra, Grb, BAout;
    logic       PC_select, Z_LO_select, MDR_select, c_select, r_select, inport_select;
    logic [4:0] alu;
  } ctl_t;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
  localparam logic [4:0] IN = 5'b10110, OUT = 5'b10111, NOP = 5'b11010, HALT = 5'b11011;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  control_unit_if bus ();
  control_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic ctl_t observe();
    ctl_t c;
    c.run = bus.run; c.PC_enable = bus.PC_enable;
    c.PC_increment_enable = bus.PC_increment_enable; c.IR_enable = bus.IR_enable;
    c.Y_enable = bus.Y_enable; c.Z_enable = bus.Z_enable; c.MAR_enable = bus.MAR_enable;
    c.MDR_enable = bus.MDR_enable; c.r_enable = bus.r_enable; c.con_enable = bus.con_enable;
    c.manual_R15_enable = bus.manual_R15_enable; c.outport_enable = bus.outport_enable;
    c.read = bus.read; c.write = bus.write; c.Gra = bus.Gra; c.Grb = bus.Grb;
    c.BAout = bus.BAout; c.PC_select = bus.PC_select; c.Z_LO_select = bus.Z_LO_select;
    c.MDR_select = bus.MDR_select; c.c_select = bus.c_select; c.r_select = bus.r_select;
    c.inport_select = bus.inport_select; c.alu = bus.alu_instruction;
    return c;
  endfunction

  function automatic int n_steps(input logic [4:0] op);
    if (op == LDI) return 6;
    if (op == LD || op == ST) return 8;
    return 4;
  endfunction

  // Reference strobe table: step index within the instruction (0 = T0).
  function automatic ctl_t model(input logic [4:0] op, input int step);
    ctl_t c = '0;
    bit mem = (op == LD) || (op == ST) || (op == LDI);
    c.run = 1'b1;
    case (step)
      0: begin c.PC_select = 1; c.MAR_enable = 1; end
      1: begin c.PC_increment_enable = 1; c.read = 1; c.MDR_enable = 1; end
      2: begin c.MDR_select = 1; c.IR_enable = 1; end
      3: if (mem) begin c.Grb = 1; c.BAout = 1; c.Y_enable = 1; end
         else if (op == IN) begin c.inport_select = 1; c.Gra = 1; c.r_enable = 1; end
         else if (op == OUT) begin c.Gra = 1; c.r_select = 1; c.outport_enable = 1; end
      4: begin c.c_select = 1; c.alu = 5'b00001; c.Z_enable = 1; end
      5: if (op == LDI) begin c.Z_LO_select = 1; c.Gra = 1; c.r_enable = 1; end
         else begin c.Z_LO_select = 1; c.MAR_enable = 1; end
      6: if (op == LD) begin c.read = 1; c.MDR_enable = 1; end
         else begin c.Gra = 1; c.r_select = 1; c.MDR_enable = 1; end
      7: if (op == LD) begin c.MDR_select = 1; c.Gra = 1; c.r_enable = 1; end
         else c.write = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one instruction from T0; IR only becomes valid from T3, stop garbage before the last step.
  task automatic exec_instr(input logic [31:0] ir, input bit stop_last,
                            input bit stop_early, input string name);
    ctl_t obs, exp;
    logic [4:0] op = ir[31:27];
    int n = n_steps(op);
    int writes = 0;
    for (int s = 0; s < n; s++) begin
      bus.IR_Data = (s >= 3) ? ir : 32'($urandom);
      bus.stop = (s == n - 1) ? stop_last : stop_early;
      #1;
      obs = observe(); exp = model(op, s);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s step T%0d: got %h expected %h", name, s, obs, exp);
      end
      if (obs.write) writes++;
      @(posedge clk); #1;
    end
    if (op == ST) begin
      checks++;
      if (writes !== 1) begin
        failures++;
        $display("FAIL %s write_cycles: got %0d expected 1", name, writes);
      end
    end
    if (op == HALT || stop_last) begin
      for (int k = 0; k < 3; k++) begin
        bus.IR_Data = 32'($urandom); bus.stop = 1'($urandom);
        #1; obs = observe();
        checks++;
        if (obs !== '0) begin
          failures++;
          $display("FAIL %s halted cycle %0d: got %h expected 0", name, k, obs);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    ctl_t obs;
    bus.IR_Data = 32'h0880_0005; bus.stop = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; obs = observe();
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_state: got %h expected 0", obs); end
    @(negedge clk); reset_n = 1'b1;
    #1; obs = observe();
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_release: got %h expected 0", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    exec_instr(32'h0880_0005, 1'b0, 1'b0, "ldi_r1_5");
    exec_instr(32'h0100_0010, 1'b0, 1'b0, "ld_r2_0x10");
    exec_instr(32'h1080_0020, 1'b0, 1'b0, "st_0x20_r1");
    exec_instr(32'hB880_0000, 1'b0, 1'b1, "out_r1");
    exec_instr(32'hB000_0000, 1'b0, 1'b1, "in_r0");
    exec_instr({NOP, 27'h0}, 1'b0, 1'b1, "nop");
    exec_instr({5'b01111, 27'h5A5}, 1'b0, 1'b1, "undefined_op");
    exec_instr(32'h0880_0005, 1'b0, 1'b0, "after_nop_ldi");
  endtask

  task automatic test_halt();
    do_reset();
    exec_instr({HALT, 27'h0}, 1'b0, 1'b0, "halt_op");
    do_reset();
    exec_instr(32'h0100_0010, 1'b1, 1'b1, "stop_mid_ld");
  endtask

  task automatic test_reset_mid_write();
    ctl_t obs, exp;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      bus.IR_Data = (s >= 3) ? 32'h1080_0020 : 32'($urandom); bus.stop = 1'b0;
      #1; obs = observe(); exp = model(ST, s);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort_st step T%0d: got %h expected %h", s, obs, exp);
      end
      if (s < 7) begin @(posedge clk); #1; end
    end
    reset_n = 1'b0;
    #1; obs = observe();
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL abort_st async_drop: got %h expected 0", obs); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    obs = observe(); exp = model(NOP, 0);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL abort_st restart_T0: got %h expected %h", obs, exp); end
  endtask

  task automatic test_random_stream();
    logic [4:0] ops [7] = '{LD, LDI, ST, IN, OUT, NOP, HALT};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int pick = $urandom_range(0, 9);
      logic [4:0] op = (pick < 7) ? ops[pick] : 5'($urandom);
      bit stp = ($urandom_range(0, 7) == 0);
      exec_instr({op, 27'($urandom)}, stp, 1'($urandom), "random");
      if (op == HALT || stp) do_reset();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exec_instr(32'h0880_0005, 1'b0, 1'b1, "b2b_ldi");
    exec_instr(32'hB880_0000, 1'b0, 1'b1, "b2b_out");
    exec_instr(32'h1080_0020, 1'b0, 1'b1, "b2b_st");
    exec_instr(32'h0100_0010, 1'b0, 1'b1, "b2b_ld");
    exec_instr(32'hB000_0000, 1'b1, 1'b0, "b2b_in_stop");
  endtask

  initial begin
    bus.IR_Data = '0;
    bus.stop = 1'b0;
    test_reset();
    test_directed();
    test_halt();
    test_reset_mid_write();
    test_random_stream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
